// File: rtl/multi_cycle_ctrl_if.sv
// rtl/multi_cycle_ctrl_if.sv - IR/flag inputs and datapath control outputs of the multi-cycle sequencer
interface multi_cycle_ctrl_if #(parameter int ST_W = 3);
  logic [5:0]      OP;
  logic [5:0]      func;
  logic            zero;
  logic            sign;
  logic            overflow;
  logic            PCWre;
  logic            IRWre;
  logic            InsMemRW;
  logic            ALUSrcA;
  logic            ALUSrcB;
  logic            ExtSel;
  logic [2:0]      ALUOp;
  logic            RegDst;
  logic            RegWre;
  logic            DBDataSrc;
  logic            mRD;
  logic            mWR;
  logic [1:0]      PCSrc;
  logic            OvfErr;
  logic [ST_W-1:0] state;

  modport master (
    input  OP, func, zero, sign, overflow,
    output PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, ALUOp, RegDst,
           RegWre, DBDataSrc, mRD, mWR, PCSrc, OvfErr, state
  );

  modport slave (
    output OP, func, zero, sign, overflow,
    input  PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, ALUOp, RegDst,
           RegWre, DBDataSrc, mRD, mWR, PCSrc, OvfErr, state
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle IF/ID/EXE/MEM/WB sequencer for the MIPS-subset datapath
module multi_cycle_ctrl #(
  parameter int         ST_W    = 3,
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input logic              CLK,
  input logic              Reset,
  multi_cycle_ctrl_if.master bus
);
  typedef enum logic [ST_W-1:0] {
    sIF     = 3'b000,
    sID     = 3'b001,
    sEXE_LS = 3'b010,
    sMEM    = 3'b011,
    sWB_L   = 3'b100,
    sEXE_BR = 3'b101,
    sEXE_AL = 3'b110,
    sWB_AL  = 3'b111
  } stateT;

  stateT state;
  logic  ovfQ;
  logic  ovfErr;

  logic isR, isAddiu, isAndi, isOri, isSlti, isLw, isSw;
  logic isBeq, isBne, isBltz, isJ, isHalt, isAlu, isBr, isNop;
  logic fAdd, fSub, fAddu, fAnd, fOr, fNor, fSll;

  assign isR     = bus.OP == 6'b000000;
  assign isAddiu = bus.OP == 6'b001001;
  assign isAndi  = bus.OP == 6'b001100;
  assign isOri   = bus.OP == 6'b001101;
  assign isSlti  = bus.OP == 6'b001010;
  assign isLw    = bus.OP == 6'b100011;
  assign isSw    = bus.OP == 6'b101011;
  assign isBeq   = bus.OP == 6'b000100;
  assign isBne   = bus.OP == 6'b000101;
  assign isBltz  = bus.OP == 6'b000001;
  assign isJ     = bus.OP == 6'b000010;
  assign isHalt  = bus.OP == HALT_OP;
  assign isAlu   = isR | isAddiu | isAndi | isOri | isSlti;
  assign isBr    = isBeq | isBne | isBltz;
  assign isNop   = !(isAlu | isLw | isSw | isBr | isJ | isHalt);

  assign fAdd  = bus.func == 6'b100000;
  assign fAddu = bus.func == 6'b100001;
  assign fSub  = bus.func == 6'b100010;
  assign fAnd  = bus.func == 6'b100100;
  assign fOr   = bus.func == 6'b100101;
  assign fNor  = bus.func == 6'b100111;
  assign fSll  = bus.func == 6'b000000;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state  <= sIF;
      ovfQ   <= 1'b0;
      ovfErr <= 1'b0;
    end else begin
      // Only signed R-type add/sub trap; ovfQ lives exactly through sWB_AL.
      ovfQ <= (state == sEXE_AL) && bus.overflow && isR && (fAdd || fSub);
      if (ovfQ) ovfErr <= 1'b1;
      case (state)
        sIF:     state <= sID;
        sID: begin
          if (isAlu)            state <= sEXE_AL;
          else if (isLw || isSw) state <= sEXE_LS;
          else if (isBr)        state <= sEXE_BR;
          else if (isHalt)      state <= sID;
          else                  state <= sIF;
        end
        sEXE_AL: state <= sWB_AL;
        sWB_AL:  state <= sIF;
        sEXE_LS: state <= sMEM;
        sMEM:    state <= isLw ? sWB_L : sIF;
        sWB_L:   state <= sIF;
        sEXE_BR: state <= sIF;
        default: state <= sIF;
      endcase
    end
  end

  logic       pcWre, irWre, regWre, regDst, dbDataSrc, memRd, memWr, brTaken;
  logic [1:0] pcSrc;
  logic [2:0] aluOp;

  assign brTaken = (isBeq && bus.zero) || (isBne && !bus.zero) || (isBltz && bus.sign);

  always_comb begin
    pcWre     = 1'b0;
    irWre     = 1'b0;
    regWre    = 1'b0;
    regDst    = 1'b0;
    dbDataSrc = 1'b0;
    memRd     = 1'b0;
    memWr     = 1'b0;
    pcSrc     = 2'b00;
    case (state)
      sIF: irWre = 1'b1;
      sID: begin
        pcWre = isJ || isNop;
        if (isJ)         pcSrc = 2'b10;
        else if (isHalt) pcSrc = 2'b11;
      end
      sMEM: begin
        memRd = isLw;
        memWr = isSw;
        pcWre = !isLw;
      end
      sWB_L: begin
        regWre    = 1'b1;
        dbDataSrc = 1'b1;
        pcWre     = 1'b1;
      end
      sEXE_BR: begin
        pcWre = 1'b1;
        pcSrc = brTaken ? 2'b01 : 2'b00;
      end
      sWB_AL: begin
        regWre = !ovfQ;
        regDst = isR;
        pcWre  = 1'b1;
      end
      default: ;
    endcase
    // Reset must suppress every write strobe even though it is sampled asynchronously.
    if (!Reset) begin
      pcWre  = 1'b0;
      irWre  = 1'b0;
      regWre = 1'b0;
      memRd  = 1'b0;
      memWr  = 1'b0;
    end
  end

  always_comb begin
    aluOp = 3'b000;
    if (isR) begin
      if (fSub)       aluOp = 3'b001;
      else if (fSll)  aluOp = 3'b010;
      else if (fOr)   aluOp = 3'b011;
      else if (fAnd)  aluOp = 3'b100;
      else if (fAddu) aluOp = 3'b101;
      else if (fNor)  aluOp = 3'b111;
    end else if (isBr)   aluOp = 3'b001;
    else if (isOri)      aluOp = 3'b011;
    else if (isAndi)     aluOp = 3'b100;
    else if (isSlti)     aluOp = 3'b110;
  end

  assign bus.PCWre     = pcWre;
  assign bus.IRWre     = irWre;
  assign bus.InsMemRW  = 1'b1;
  assign bus.ALUSrcA   = isR && fSll;
  assign bus.ALUSrcB   = isAddiu || isAndi || isOri || isSlti || isLw || isSw;
  assign bus.ExtSel    = !(isAndi || isOri);
  assign bus.ALUOp     = aluOp;
  assign bus.RegDst    = regDst;
  assign bus.RegWre    = regWre;
  assign bus.DBDataSrc = dbDataSrc;
  assign bus.mRD       = memRd;
  assign bus.mWR       = memWr;
  assign bus.PCSrc     = pcSrc;
  assign bus.OvfErr    = ovfErr;
  assign bus.state     = state;
endmodule
